axi_w_dest_router: RTL and testbench

//  Write-data stage directly downstream of the AW address decoder in the axi_node slave-port slice.

---
 rtl/axi_w_dest_router_pkg.sv | 14 +
 rtl/axi_w_dest_router_if.sv | 44 ++++
 rtl/axi_w_dest_router_fifo.sv | 55 +++++
 rtl/axi_w_dest_router.sv | 90 +++++++++
 tb/tb_axi_w_dest_router.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_w_dest_router_pkg.sv
// Shared types and defaults for the axi_node W-channel destination router.
package axi_node_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    SINK  = 2'd2,
    DONE  = 2'd3
  } w_route_state_e;

  localparam int unsigned DEST_FIFO_DEPTH = 4;
  localparam int unsigned DEST_FIFO_PTR_W = $clog2(DEST_FIFO_DEPTH);

endpackage

// File: rtl/axi_w_dest_router_if.sv
// Decoder handshake plus master-side and port-side W channel of the destination router.
interface axi_w_dest_router_if #(
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned AXI_DATA_W  = 64,
  parameter int unsigned AXI_USER_W  = 6
);

  logic                    push_DEST_i;
  logic [N_INIT_PORT-1:0]  DEST_i;
  logic                    grant_FIFO_DEST_o;
  logic                    handle_error_i;
  logic                    wdata_error_completed_o;

  logic [AXI_DATA_W-1:0]   wdata_i;
  logic [AXI_DATA_W/8-1:0] wstrb_i;
  logic [AXI_USER_W-1:0]   wuser_i;
  logic                    wlast_i;
  logic                    wvalid_i;
  logic                    wready_o;

  logic [AXI_DATA_W-1:0]   wdata_o;
  logic [AXI_DATA_W/8-1:0] wstrb_o;
  logic [AXI_USER_W-1:0]   wuser_o;
  logic                    wlast_o;
  logic [N_INIT_PORT-1:0]  wvalid_o;
  logic [N_INIT_PORT-1:0]  wready_i;

  // Router side
  modport slave (
    input  push_DEST_i, DEST_i, handle_error_i,
    input  wdata_i, wstrb_i, wuser_i, wlast_i, wvalid_i, wready_i,
    output grant_FIFO_DEST_o, wdata_error_completed_o, wready_o,
    output wdata_o, wstrb_o, wuser_o, wlast_o, wvalid_o
  );

  // Environment side (decoder, W master and target ports)
  modport master (
    output push_DEST_i, DEST_i, handle_error_i,
    output wdata_i, wstrb_i, wuser_i, wlast_i, wvalid_i, wready_i,
    input  grant_FIFO_DEST_o, wdata_error_completed_o, wready_o,
    input  wdata_o, wstrb_o, wuser_o, wlast_o, wvalid_o
  );

endinterface

// File: rtl/axi_w_dest_router_fifo.sv
// In-order queue of one-hot W destinations; a push at full is accepted only alongside a pop.
module axi_dest_fifo #(
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [N_INIT_PORT-1:0] din,
  output logic                   full,
  output logic                   empty,
  output logic                   last_entry,
  output logic [N_INIT_PORT-1:0] head
);

  localparam int unsigned       PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [N_INIT_PORT-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;
  logic                   do_push, do_pop;

  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign last_entry = (count == (PTR_W+1)'(1));
  assign head       = mem[rd_ptr];

  // Power-of-2 depth lets the pointers wrap by natural overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !do_pop));

endmodule

// File: rtl/axi_w_dest_router.sv
// W-channel steering behind the AW decoder: routes bursts in DEST order, sinks decode-error bursts.
module axi_w_dest_router
  import axi_node_pkg::*;
#(
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned FIFO_DEPTH  = DEST_FIFO_DEPTH,
  parameter int unsigned AXI_DATA_W  = 64,
  parameter int unsigned AXI_USER_W  = 6
) (
  input logic                clk,
  input logic                rst,
  axi_w_dest_router_if.slave bus
);

  w_route_state_e         state_q, state_d;
  logic [N_INIT_PORT-1:0] head;
  logic                   full, empty, last_entry, pop;
  logic [N_INIT_PORT-1:0] wvalid;
  logic                   wready, completed;

  axi_dest_fifo #(
    .N_INIT_PORT (N_INIT_PORT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_dest_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (bus.push_DEST_i),
    .pop        (pop),
    .din        (bus.DEST_i),
    .full       (full),
    .empty      (empty),
    .last_entry (last_entry),
    .head       (head)
  );

  assign bus.grant_FIFO_DEST_o       = !full;
  assign bus.wdata_error_completed_o = completed;
  assign bus.wready_o                = wready;
  assign bus.wvalid_o                = wvalid;

  assign bus.wdata_o = AXI_DATA_W'(bus.wdata_i);
  assign bus.wstrb_o = (AXI_DATA_W/8)'(bus.wstrb_i);
  assign bus.wuser_o = AXI_USER_W'(bus.wuser_i);
  assign bus.wlast_o = bus.wlast_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wvalid    = '0;
    wready    = 1'b0;
    completed = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty)                  state_d = ROUTE;
        else if (bus.handle_error_i) state_d = SINK;
      end
      ROUTE: begin
        wvalid = {N_INIT_PORT{bus.wvalid_i}} & head;
        wready = |(bus.wready_i & head);
        if (bus.wvalid_i && wready && bus.wlast_i) begin
          pop = 1'b1;
          // A push landing with the final pop keeps the queue alive: no bubble
          if (last_entry && !(bus.push_DEST_i && !full)) state_d = IDLE;
        end
      end
      SINK: begin
        wready = 1'b1;
        if (bus.wvalid_i && bus.wlast_i) state_d = DONE;
      end
      DONE: begin
        completed = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  a_head_onehot: assert property (@(posedge clk) disable iff (rst) (state_q == ROUTE) |-> $onehot(head));
  a_wvalid_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.wvalid_o));
  a_sink_from_idle: assert property (@(posedge clk) disable iff (rst)
    (state_q == SINK && $past(state_q) != SINK) |-> ($past(state_q) == IDLE && $past(bus.handle_error_i)));
  a_done_from_sink: assert property (@(posedge clk) disable iff (rst)
    (state_q == DONE) |-> ($past(state_q) == SINK));

endmodule

// File: tb/tb_axi_w_dest_router.sv
// Directed bench for axi_w_dest_router: routing, back-to-back, full FIFO, error sink, reset.
module tb_axi_w_dest_router;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  axi_w_dest_router_if #(.N_INIT_PORT(8), .AXI_DATA_W(64), .AXI_USER_W(6)) bus ();

  axi_w_dest_router #(
    .N_INIT_PORT (8),
    .FIFO_DEPTH  (4),
    .AXI_DATA_W  (64),
    .AXI_USER_W  (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.push_DEST_i    = 1'b0;
    bus.DEST_i         = '0;
    bus.handle_error_i = 1'b0;
    bus.wdata_i        = '0;
    bus.wstrb_i        = '0;
    bus.wuser_i        = '0;
    bus.wlast_i        = 1'b0;
    bus.wvalid_i       = 1'b0;
    bus.wready_i       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    n_tests++;
    if (bus.wvalid_o !== 8'h00 || bus.wready_o !== 1'b0 || bus.wdata_error_completed_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: wvalid_o=%h wready_o=%b completed=%b, expected 00 0 0",
               bus.wvalid_o, bus.wready_o, bus.wdata_error_completed_o);
    end
    n_tests++;
    if (bus.grant_FIFO_DEST_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_grant: got %b expected 1", bus.grant_FIFO_DEST_o);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_burst();
    bus.push_DEST_i = 1'b1;
    bus.DEST_i      = 8'h04;
    tick();
    bus.push_DEST_i = 1'b0;
    bus.DEST_i      = '0;
    bus.wvalid_i    = 1'b1;
    bus.wready_i    = 8'hFF;
    n_tests++;
    if (bus.wready_o !== 1'b0 || bus.wvalid_o !== 8'h00) begin
      n_fail++;
      $display("FAIL single_latency1: wready_o=%b wvalid_o=%h, expected 0 00", bus.wready_o, bus.wvalid_o);
    end
    tick();
    for (int unsigned b = 0; b < 4; b++) begin
      bus.wdata_i = 64'hA5A5_0000_0000_0000 | 64'(b);
      bus.wstrb_i = 8'hF0 | 8'(b);
      bus.wuser_i = 6'(b + 3);
      bus.wlast_i = (b == 3);
      #1;
      n_tests++;
      if (bus.wvalid_o !== 8'h04 || bus.wready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL single_beat%0d: wvalid_o=%h wready_o=%b, expected 04 1", b, bus.wvalid_o, bus.wready_o);
      end
      n_tests++;
      if (bus.wdata_o !== (64'hA5A5_0000_0000_0000 | 64'(b)) || bus.wstrb_o !== (8'hF0 | 8'(b)) ||
          bus.wuser_o !== 6'(b + 3) || bus.wlast_o !== (b == 3)) begin
        n_fail++;
        $display("FAIL single_payload%0d: data=%h strb=%h user=%h last=%b", b,
                 bus.wdata_o, bus.wstrb_o, bus.wuser_o, bus.wlast_o);
      end
      tick();
    end
    bus.wlast_i = 1'b0;
    n_tests++;
    if (bus.wready_o !== 1'b0 || bus.wvalid_o !== 8'h00 || bus.grant_FIFO_DEST_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: wready_o=%b wvalid_o=%h grant=%b, expected 0 00 1",
               bus.wready_o, bus.wvalid_o, bus.grant_FIFO_DEST_o);
    end
    tick();
    n_tests++;
    if (bus.wready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_empty: wready_o=%b expected 0 (FIFO should be empty)", bus.wready_o);
    end
    bus.wvalid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.push_DEST_i = 1'b1;
    bus.DEST_i      = 8'h01;
    tick();
    bus.DEST_i      = 8'h80;
    tick();
    bus.push_DEST_i = 1'b0;
    bus.DEST_i      = '0;
    bus.wready_i    = 8'h7F;
    bus.wvalid_i    = 1'b1;
    for (int unsigned b = 0; b < 2; b++) begin
      bus.wlast_i = (b == 1);
      #1;
      n_tests++;
      if (bus.wvalid_o !== 8'h01 || bus.wready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_port0_beat%0d: wvalid_o=%h wready_o=%b, expected 01 1", b, bus.wvalid_o, bus.wready_o);
      end
      tick();
    end
    bus.wlast_i = 1'b0;
    for (int unsigned s = 0; s < 3; s++) begin
      n_tests++;
      if (bus.wvalid_o !== 8'h80 || bus.wready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_stall%0d: wvalid_o=%h wready_o=%b, expected 80 0", s, bus.wvalid_o, bus.wready_o);
      end
      tick();
    end
    bus.wready_i = 8'hFF;
    for (int unsigned b = 0; b < 2; b++) begin
      bus.wlast_i = (b == 1);
      #1;
      n_tests++;
      if (bus.wvalid_o !== 8'h80 || bus.wready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_port7_beat%0d: wvalid_o=%h wready_o=%b, expected 80 1", b, bus.wvalid_o, bus.wready_o);
      end
      tick();
    end
    bus.wlast_i = 1'b0;
    n_tests++;
    if (bus.wready_o !== 1'b0 || bus.wvalid_o !== 8'h00) begin
      n_fail++;
      $display("FAIL b2b_idle: wready_o=%b wvalid_o=%h, expected 0 00", bus.wready_o, bus.wvalid_o);
    end
    bus.wvalid_i = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [7:0] pushed [4];
    logic [7:0] drain  [4];
    pushed = '{8'h01, 8'h02, 8'h04, 8'h08};
    drain  = '{8'h02, 8'h04, 8'h08, 8'h10};
    bus.wready_i = 8'hFF;
    for (int unsigned i = 0; i < 4; i++) begin
      n_tests++;
      if (bus.grant_FIFO_DEST_o !== 1'b1) begin
        n_fail++;
        $display("FAIL full_grant_before%0d: got %b expected 1", i, bus.grant_FIFO_DEST_o);
      end
      bus.push_DEST_i = 1'b1;
      bus.DEST_i      = pushed[i];
      tick();
    end
    bus.push_DEST_i = 1'b0;
    n_tests++;
    if (bus.grant_FIFO_DEST_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_grant_after4: got %b expected 0", bus.grant_FIFO_DEST_o);
    end
    bus.push_DEST_i = 1'b1;
    bus.DEST_i      = 8'h10;
    bus.wvalid_i    = 1'b1;
    bus.wlast_i     = 1'b1;
    #1;
    n_tests++;
    if (bus.wvalid_o !== 8'h01 || bus.wready_o !== 1'b1 || bus.grant_FIFO_DEST_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pushpop: wvalid_o=%h wready_o=%b grant=%b, expected 01 1 0",
               bus.wvalid_o, bus.wready_o, bus.grant_FIFO_DEST_o);
    end
    tick();
    bus.push_DEST_i = 1'b0;
    bus.DEST_i      = '0;
    n_tests++;
    if (bus.grant_FIFO_DEST_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_count_kept: grant=%b expected 0", bus.grant_FIFO_DEST_o);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      n_tests++;
      if (bus.wvalid_o !== drain[i] || bus.wready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL full_drain%0d: wvalid_o=%h wready_o=%b, expected %h 1", i, bus.wvalid_o, bus.wready_o, drain[i]);
      end
      tick();
      n_tests++;
      if (bus.grant_FIFO_DEST_o !== 1'b1) begin
        n_fail++;
        $display("FAIL full_grant_drain%0d: got %b expected 1", i, bus.grant_FIFO_DEST_o);
      end
    end
    n_tests++;
    if (bus.wready_o !== 1'b0 || bus.wvalid_o !== 8'h00) begin
      n_fail++;
      $display("FAIL full_idle: wready_o=%b wvalid_o=%h, expected 0 00", bus.wready_o, bus.wvalid_o);
    end
    bus.wvalid_i = 1'b0;
    bus.wlast_i  = 1'b0;
  endtask

  task automatic sink_burst(input string tag, input int unsigned beats);
    for (int unsigned b = 0; b < beats; b++) begin
      bus.wvalid_i = 1'b1;
      bus.wlast_i  = (b == beats - 1);
      #1;
      n_tests++;
      if (bus.wready_o !== 1'b1 || bus.wvalid_o !== 8'h00 || bus.wdata_error_completed_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_sink_beat%0d: wready_o=%b wvalid_o=%h completed=%b, expected 1 00 0",
                 tag, b, bus.wready_o, bus.wvalid_o, bus.wdata_error_completed_o);
      end
      tick();
    end
    bus.wvalid_i = 1'b0;
    bus.wlast_i  = 1'b0;
    n_tests++;
    if (bus.wdata_error_completed_o !== 1'b1 || bus.wready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: completed=%b wready_o=%b, expected 1 0", tag, bus.wdata_error_completed_o, bus.wready_o);
    end
    bus.handle_error_i = 1'b0;
    tick();
    n_tests++;
    if (bus.wdata_error_completed_o !== 1'b0 || bus.wready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after_done: completed=%b wready_o=%b, expected 0 0", tag, bus.wdata_error_completed_o, bus.wready_o);
    end
  endtask

  task automatic test_error_sink();
    bus.wready_i       = 8'hFF;
    bus.handle_error_i = 1'b1;
    #1;
    n_tests++;
    if (bus.wready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_idle: wready_o=%b expected 0", bus.wready_o);
    end
    tick();
    sink_burst("err", 3);
  endtask

  task automatic test_route_before_error();
    bus.wready_i    = 8'hFF;
    bus.push_DEST_i = 1'b1;
    bus.DEST_i      = 8'h02;
    tick();
    bus.push_DEST_i    = 1'b0;
    bus.DEST_i         = '0;
    bus.handle_error_i = 1'b1;
    tick();
    bus.wvalid_i = 1'b1;
    for (int unsigned b = 0; b < 2; b++) begin
      bus.wlast_i = (b == 1);
      #1;
      n_tests++;
      if (bus.wvalid_o !== 8'h02 || bus.wready_o !== 1'b1 || bus.wdata_error_completed_o !== 1'b0) begin
        n_fail++;
        $display("FAIL prio_route_beat%0d: wvalid_o=%h wready_o=%b completed=%b, expected 02 1 0",
                 b, bus.wvalid_o, bus.wready_o, bus.wdata_error_completed_o);
      end
      tick();
    end
    bus.wvalid_i = 1'b0;
    bus.wlast_i  = 1'b0;
    n_tests++;
    if (bus.wready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_idle: wready_o=%b expected 0", bus.wready_o);
    end
    tick();
    sink_burst("prio", 2);
  endtask

  task automatic test_reset_mid_burst();
    bus.wready_i    = 8'hFF;
    bus.push_DEST_i = 1'b1;
    bus.DEST_i      = 8'h08;
    tick();
    bus.push_DEST_i = 1'b0;
    bus.DEST_i      = '0;
    tick();
    bus.wvalid_i = 1'b1;
    bus.wlast_i  = 1'b0;
    tick();
    n_tests++;
    if (bus.wvalid_o !== 8'h08) begin
      n_fail++;
      $display("FAIL rst_pre: wvalid_o=%h expected 08", bus.wvalid_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.wvalid_o !== 8'h00 || bus.wready_o !== 1'b0 || bus.grant_FIFO_DEST_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: wvalid_o=%h wready_o=%b grant=%b, expected 00 0 1",
               bus.wvalid_o, bus.wready_o, bus.grant_FIFO_DEST_o);
    end
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (bus.wready_o !== 1'b0 || bus.wvalid_o !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_flushed: wready_o=%b wvalid_o=%h, expected 0 00", bus.wready_o, bus.wvalid_o);
    end
    bus.push_DEST_i = 1'b1;
    bus.DEST_i      = 8'h20;
    tick();
    bus.push_DEST_i = 1'b0;
    bus.DEST_i      = '0;
    tick();
    bus.wlast_i = 1'b1;
    #1;
    n_tests++;
    if (bus.wvalid_o !== 8'h20 || bus.wready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_post_route: wvalid_o=%h wready_o=%b, expected 20 1", bus.wvalid_o, bus.wready_o);
    end
    tick();
    bus.wvalid_i = 1'b0;
    bus.wlast_i  = 1'b0;
    n_tests++;
    if (bus.wready_o !== 1'b0 || bus.grant_FIFO_DEST_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_post_idle: wready_o=%b grant=%b, expected 0 1", bus.wready_o, bus.grant_FIFO_DEST_o);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single_burst();
    tick();
    test_back_to_back();
    tick();
    test_fifo_full();
    tick();
    test_error_sink();
    tick();
    test_route_before_error();
    tick();
    test_reset_mid_burst();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
